mem_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer sitting between the CPU's instruction-fetch and load/store units and the single `mmu` instance. It picks one requester per transaction (round-robin on contention), latches its request, and drives the MMU's level-sensitive request interface for exactly one issue cycle. It holds address and data stable until `mem_ready` reports completion, then returns a one-cycle acknowledge with registered read data to the owning requester. A watchdog terminates transactions whose `mem_ready` never returns.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_arb_rr2.sv | 40 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: MMU access widths, FSM states and
// transaction-owner codes.
package mem_arbiter_pkg;

   localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
   localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
   localparam logic [1:0] MMU_WIDTH_WORD = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   localparam logic ARB_OWN_IF = 1'b0;
   localparam logic ARB_OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-requester round-robin picker. Bit 0 is fetch, bit 1 is data; a tie goes
// to the port that did not win the previous update.
module arb_rr2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);
   import mem_arbiter_pkg::*;

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant_q == ARB_OWN_DM) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (update && (grant != 2'b00)) begin
         last_grant_d = grant[1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= ARB_OWN_DM;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto the single MMU port: one issue
// cycle, wait for mmu_ready (or watchdog), then a one-cycle ack to the owner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic        dm_signed,
   input  logic [1:0]  dm_width,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mmu_read_enable,
   output logic        mmu_write_enable,
   output logic        mmu_signed_read,
   output logic [1:0]  mmu_data_width,
   output logic [31:0] mmu_address,
   output logic [31:0] mmu_data_in,
   input  logic [31:0] mmu_data_out,
   input  logic        mmu_ready,
   output logic [1:0]  dbg_state
);

   arb_state_e  state_q, state_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic        signed_q, signed_d;
   logic [1:0]  width_q, width_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] wd_cnt_q, wd_cnt_d;

   logic [1:0]  grant;
   logic        grant_update;

   assign grant_update = (state_q == ARB_IDLE) && mmu_ready;

   arb_rr2 u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    ({dm_req, if_req}),
      .update (grant_update),
      .grant  (grant)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      signed_d = signed_q;
      width_d  = width_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      wd_cnt_d = wd_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_update && (grant != 2'b00)) begin
               state_d = ARB_ISSUE;
               if (grant[0]) begin
                  owner_d  = ARB_OWN_IF;
                  we_d     = 1'b0;
                  signed_d = 1'b0;
                  width_d  = MMU_WIDTH_WORD;
                  addr_d   = if_addr;
                  wdata_d  = 32'd0;
               end else begin
                  owner_d  = ARB_OWN_DM;
                  we_d     = dm_we;
                  signed_d = dm_signed;
                  width_d  = dm_width;
                  addr_d   = dm_addr;
                  wdata_d  = dm_wdata;
               end
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (mmu_ready) begin
               rdata_d = we_q ? 32'd0 : mmu_data_out;
               state_d = ARB_RESP;
            end else if ((TIMEOUT != 0) && (wd_cnt_q == 32'(TIMEOUT - 1))) begin
               // Watchdog expiry completes the transaction with an error flag.
               err_d   = 1'b1;
               rdata_d = 32'd0;
               state_d = ARB_RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
         end
         ARB_RESP: begin
            state_d  = ARB_IDLE;
            wd_cnt_d = 32'd0;
            err_d    = 1'b0;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         owner_q  <= ARB_OWN_IF;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         width_q  <= 2'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         wd_cnt_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         signed_q <= signed_d;
         width_q  <= width_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   // Access attributes stay on the bus through WAIT: the MMU reads them combinationally.
   logic in_xact;
   logic resp;
   assign in_xact = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
   assign resp    = (state_q == ARB_RESP);

   assign mmu_read_enable  = (state_q == ARB_ISSUE) && !we_q;
   assign mmu_write_enable = (state_q == ARB_ISSUE) && we_q;
   assign mmu_signed_read  = in_xact && signed_q;
   assign mmu_data_width   = in_xact ? width_q : 2'd0;
   assign mmu_address      = in_xact ? addr_q : 32'd0;
   assign mmu_data_in      = in_xact ? wdata_q : 32'd0;

   assign if_ack   = resp && (owner_q == ARB_OWN_IF);
   assign if_rdata = if_ack ? rdata_q : 32'd0;
   assign if_err   = if_ack && err_q;
   assign dm_ack   = resp && (owner_q == ARB_OWN_DM);
   assign dm_rdata = dm_ack ? rdata_q : 32'd0;
   assign dm_err   = dm_ack && err_q;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a stub MMU; expected acks are queued at
// stimulus time and popped by an independent monitor.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic        dm_signed;
   logic [1:0]  dm_width;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        mmu_read_enable;
   logic        mmu_write_enable;
   logic        mmu_signed_read;
   logic [1:0]  mmu_data_width;
   logic [31:0] mmu_address;
   logic [31:0] mmu_data_in;
   logic [31:0] mmu_data_out;
   logic        mmu_ready;
   logic [1:0]  dbg_state;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_ack           (if_ack),
      .if_rdata         (if_rdata),
      .if_err           (if_err),
      .dm_req           (dm_req),
      .dm_we            (dm_we),
      .dm_signed        (dm_signed),
      .dm_width         (dm_width),
      .dm_addr          (dm_addr),
      .dm_wdata         (dm_wdata),
      .dm_ack           (dm_ack),
      .dm_rdata         (dm_rdata),
      .dm_err           (dm_err),
      .mmu_read_enable  (mmu_read_enable),
      .mmu_write_enable (mmu_write_enable),
      .mmu_signed_read  (mmu_signed_read),
      .mmu_data_width   (mmu_data_width),
      .mmu_address      (mmu_address),
      .mmu_data_in      (mmu_data_in),
      .mmu_data_out     (mmu_data_out),
      .mmu_ready        (mmu_ready),
      .dbg_state        (dbg_state)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- stub MMU ----------------
   // Busy from the issue strobe for mmu_lat extra WAIT cycles; stuck/block force ready low.
   int          mmu_lat = 0;
   int          mmu_cnt = 0;
   bit          mmu_busy = 1'b0;
   bit          mmu_stuck = 1'b0;
   bit          mmu_block = 1'b0;
   logic [31:0] mmu_dout = 32'd0;

   assign mmu_ready    = !mmu_stuck && !mmu_block && !mmu_busy;
   assign mmu_data_out = mmu_dout;

   function automatic logic [31:0] rom(logic [31:0] a);
      case (a)
         32'h0000_0004: rom = 32'h0050_0093;
         32'h0000_0010: rom = 32'h0BAD_F00D;
         32'h0000_0020: rom = 32'hCAFE_F00D;
         32'h0100_0000: rom = 32'h1234_5678;
         32'h0100_0002: rom = 32'hFFFF_8001;
         default:       rom = 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         mmu_busy = 1'b0;
         mmu_cnt  = 0;
      end else if (mmu_read_enable || mmu_write_enable) begin
         mmu_busy = 1'b1;
         mmu_cnt  = mmu_lat;
         mmu_dout = mmu_write_enable ? 32'hFFFF_FFFF : rom(mmu_address);
      end else if (mmu_busy) begin
         if (mmu_cnt > 0) mmu_cnt--;
         else mmu_busy = 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   // Entry: {port(1), err(1), rdata(32), ack cycle(32)}
   logic [65:0] exp_q[$];

   task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata, input int at);
      exp_q.push_back({port, err, rdata, 32'(at)});
   endtask

   always @(negedge clk) begin
      logic [65:0] e;
      if (if_ack || dm_ack) begin
         check("single_ack", {63'd0, if_ack & dm_ack}, 64'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual if_ack=%0b dm_ack=%0b required none (cycle %0d)",
                     if_ack, dm_ack, cyc);
         end else begin
            e = exp_q.pop_front();
            check("ack_port", {63'd0, dm_ack}, {63'd0, e[65]});
            check("ack_rdata", {32'd0, dm_ack ? dm_rdata : if_rdata}, {32'd0, e[63:32]});
            check("ack_err", {63'd0, dm_ack ? dm_err : if_err}, {63'd0, e[64]});
            check("ack_cycle", 64'(cyc), {32'd0, e[31:0]});
            check("other_port_quiet", {31'd0, dm_ack ? {if_rdata, if_err} : {dm_rdata, dm_err}}, 64'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input bit port, input int budget);
      int n = 0;
      while (!(port ? dm_ack : if_ack) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         failures++;
         $display("FAIL ack_wait_expired actual no ack required ack on port %0d within %0d cycles",
                  port, budget);
      end
   endtask

   task automatic check_all_zero(string name);
      check(name, {63'd0, |{if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
                            mmu_read_enable, mmu_write_enable, mmu_signed_read,
                            mmu_data_width, mmu_address, mmu_data_in}}, 64'd0);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_outputs");
      check("reset_state", {62'd0, dbg_state}, {62'd0, ARB_IDLE});
      reset = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0;
      reset = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      dm_req = 1'b0; dm_we = 1'b0; dm_signed = 1'b0; dm_width = 2'd0;
      dm_addr = 32'd0; dm_wdata = 32'd0;
      do_reset();

      // Contention out of reset: fetch first, load next, third tie back to fetch.
      @(negedge clk);
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_width = MMU_WIDTH_WORD; dm_addr = 32'h0100_0000;
      push_exp(ARB_OWN_IF, 1'b0, 32'h0BAD_F00D, t0 + 3);
      push_exp(ARB_OWN_DM, 1'b0, 32'h1234_5678, t0 + 7);
      @(negedge clk);
      check("cont_first_addr", {32'd0, mmu_address}, 64'h10);
      wait_ack(1'b0, 10); if_req = 1'b0;
      wait_ack(1'b1, 10); dm_req = 1'b0;
      @(negedge clk);
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1;
      push_exp(ARB_OWN_IF, 1'b0, 32'h0050_0093, t0 + 3);
      push_exp(ARB_OWN_DM, 1'b0, 32'h1234_5678, t0 + 7);
      @(negedge clk);
      check("cont_third_addr", {32'd0, mmu_address}, 64'h4);
      wait_ack(1'b0, 10); if_req = 1'b0;
      wait_ack(1'b1, 10); dm_req = 1'b0;

      // Fetch only.
      @(negedge clk);
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h4;
      push_exp(ARB_OWN_IF, 1'b0, 32'h0050_0093, t0 + 3);
      @(negedge clk);
      check("fetch_issue_state", {62'd0, dbg_state}, {62'd0, ARB_ISSUE});
      check("fetch_issue_strobes", {62'd0, mmu_read_enable, mmu_write_enable}, 64'h2);
      check("fetch_issue_width", {62'd0, mmu_data_width}, {62'd0, MMU_WIDTH_WORD});
      check("fetch_issue_signed", {63'd0, mmu_signed_read}, 64'd0);
      check("fetch_issue_addr", {32'd0, mmu_address}, 64'h4);
      wait_ack(1'b0, 10); if_req = 1'b0;

      // Byte store with one stalled WAIT cycle.
      mmu_lat = 1;
      @(negedge clk);
      t0 = cyc;
      dm_req = 1'b1; dm_we = 1'b1; dm_width = MMU_WIDTH_BYTE; dm_signed = 1'b0;
      dm_addr = 32'h0100_0001; dm_wdata = 32'hAB;
      push_exp(ARB_OWN_DM, 1'b0, 32'd0, t0 + 4);
      @(negedge clk);
      check("store_issue_strobes", {62'd0, mmu_read_enable, mmu_write_enable}, 64'h1);
      check("store_issue_width", {62'd0, mmu_data_width}, {62'd0, MMU_WIDTH_BYTE});
      check("store_issue_addr", {32'd0, mmu_address}, 64'h0100_0001);
      check("store_issue_wdata", {32'd0, mmu_data_in}, 64'hAB);
      @(negedge clk);
      check("store_wait_state", {62'd0, dbg_state}, {62'd0, ARB_WAIT});
      check("store_wait_strobes", {62'd0, mmu_read_enable, mmu_write_enable}, 64'h0);
      check("store_wait_addr", {32'd0, mmu_address}, 64'h0100_0001);
      @(negedge clk);
      check("store_wait2_addr", {32'd0, mmu_address}, 64'h0100_0001);
      check("store_wait2_wdata", {32'd0, mmu_data_in}, 64'hAB);
      wait_ack(1'b1, 10); dm_req = 1'b0; dm_we = 1'b0; mmu_lat = 0;

      // Watchdog: MMU never returns ready after issue.
      @(negedge clk);
      t0 = cyc;
      dm_req = 1'b1; dm_width = MMU_WIDTH_WORD; dm_addr = 32'h20;
      push_exp(ARB_OWN_DM, 1'b1, 32'd0, t0 + 6);
      @(negedge clk);
      mmu_stuck = 1'b1;
      check("timeout_issue_rd", {63'd0, mmu_read_enable}, 64'd1);
      wait_ack(1'b1, 12); dm_req = 1'b0; mmu_stuck = 1'b0;
      @(negedge clk);
      check("timeout_back_idle", {62'd0, dbg_state}, {62'd0, ARB_IDLE});

      // Reset during WAIT: asynchronous clear, no ack, pending fetch granted afterwards.
      mmu_lat = 5;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h4;
      repeat (2) @(negedge clk);
      check("rst_mid_state_wait", {62'd0, dbg_state}, {62'd0, ARB_WAIT});
      #1 reset = 1'b1;
      #1;
      check_all_zero("rst_mid_outputs");
      check("rst_mid_state", {62'd0, dbg_state}, {62'd0, ARB_IDLE});
      mmu_lat = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      t0 = cyc;
      push_exp(ARB_OWN_IF, 1'b0, 32'h0050_0093, t0 + 3);
      wait_ack(1'b0, 10); if_req = 1'b0;

      // Persistent fetch request: second ISSUE exactly 4 cycles after the first.
      @(negedge clk);
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h4;
      push_exp(ARB_OWN_IF, 1'b0, 32'h0050_0093, t0 + 3);
      push_exp(ARB_OWN_IF, 1'b0, 32'h0050_0093, t0 + 7);
      @(negedge clk);
      check("persist_issue1", {62'd0, dbg_state}, {62'd0, ARB_ISSUE});
      wait_ack(1'b0, 10);
      @(negedge clk);
      check("persist_gap_idle", {62'd0, dbg_state}, {62'd0, ARB_IDLE});
      @(negedge clk);
      check("persist_issue2", {62'd0, dbg_state}, {62'd0, ARB_ISSUE});
      check("persist_issue2_rd", {63'd0, mmu_read_enable}, 64'd1);
      wait_ack(1'b0, 10); if_req = 1'b0;
      repeat (3) @(negedge clk);

      // mmu_ready low in IDLE blocks the grant; fields changed while pending take effect.
      mmu_block = 1'b1;
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_signed = 1'b1; dm_width = MMU_WIDTH_HALF;
      dm_addr = 32'h0100_0010;
      @(negedge clk);
      check("blocked_idle1", {62'd0, dbg_state}, {62'd0, ARB_IDLE});
      dm_addr = 32'h0100_0002;
      @(negedge clk);
      check("blocked_idle2", {62'd0, dbg_state}, {62'd0, ARB_IDLE});
      mmu_block = 1'b0;
      t0 = cyc;
      push_exp(ARB_OWN_DM, 1'b0, 32'hFFFF_8001, t0 + 3);
      @(negedge clk);
      check("late_field_addr", {32'd0, mmu_address}, 64'h0100_0002);
      check("late_field_signed", {63'd0, mmu_signed_read}, 64'd1);
      check("late_field_width", {62'd0, mmu_data_width}, {62'd0, MMU_WIDTH_HALF});
      wait_ack(1'b1, 10); dm_req = 1'b0; dm_signed = 1'b0;
      repeat (3) @(negedge clk);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_time_limit actual still running required finished");
      $fatal(1, "time limit");
   end

endmodule
